registro_tiros: RTL
===================

// Module: registro_tiros
// PURPOSE
//  Write side of the board memories that the score counter (Pontuacao) reads. Holds each player's 8x8 ship map.
//  Accepts alternating shots and builds the 64-bit hit maps memoriaP1/memoriaP2.
//  After every accepted shot it pulses enable to the score counter and waits for ready.
//  It then latches pontuacao_P1/P2 and declares a winner at WIN_SCORE.
// PARAMETERS
//  WIN_SCORE     4'd10  score (hit cells) that ends the game
//  FIRST_PLAYER  1'b0   player owning the first turn (0=P1, 1=P2)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset_n       in   1   synchronous, active-low reset
//  load_valid    in   1   ship-map write strobe (LOAD state only)
//  load_player   in   1   0=P1 board, 1=P2 board
//  load_map      in   64  ship map, bit {y,x}=1 -> ship cell
//  shot_valid    in   1   shot request from current player
//  shot_ready    out  1   high in TURNO state; shot taken when valid&&ready
//  shot_x        in   3   column 0..7
//  shot_y        in   3   row 0..7
//  shot_err      out  1   1-cycle pulse: repeated cell, shot rejected
//  shot_hit      out  1   1-cycle pulse: accepted shot hit a ship
//  turno         out  1   player to shoot (0=P1, 1=P2)
//  memoriaP1     out  64  cells of P2's board hit by P1
//  memoriaP2     out  64  cells of P1's board hit by P2
//  enable        out  1   1-cycle request to score counter
//  ready         in   1   score counter done; pontuacao_* valid
//  pontuacao_P1  in   4   score from counter
//  pontuacao_P2  in   4   score from counter
//  placar_P1     out  4   latched P1 score
//  placar_P2     out  4   latched P2 score
//  fim_jogo      out  1   game over, held until reset
//  vencedor      out  1   winner (0=P1, 1=P2), valid when fim_jogo
// BEHAVIOUR
//  Reset (reset_n=0 at edge) clears all maps, placar, fim_jogo, vencedor, enable, pulses.
//    turno=FIRST_PLAYER; state=LOAD. Reset mid-game aborts any pending score request.
//  Cell index idx = {shot_y,shot_x}. Shot maps tiro_P1/tiro_P2 (64b) record every cell fired at.
//  FSM: LOAD -> TURNO -> CHECK -> REQ -> WAIT -> TURNO | FIM.
//  LOAD: load_valid writes load_map to ship map of load_player. Rewrites overwrite.
//    Leave LOAD once both boards have been written at least once.
//  TURNO: shot_ready=1. On valid&&ready capture idx, go to CHECK. Otherwise hold.
//  CHECK (1 cycle) for shooter s:
//    tiro_s[idx]=1 -> shot_err pulse, no map change, turno unchanged, back to TURNO.
//    Else set tiro_s[idx]. If opponent ship[idx]=1, set memoria_s[idx] and pulse shot_hit.
//      Hit: turno unchanged. Miss: turno toggles. Go to REQ.
//  REQ: enable=1 for exactly one cycle; memoria* already updated and stable. Go to WAIT.
//  WAIT: enable=0; wait for ready=1, sampled from the cycle after REQ.
//    ready=1: placar_P1<=pontuacao_P1, placar_P2<=pontuacao_P2.
//    If either latched value >= WIN_SCORE: FIM, vencedor = player reaching it (P1 on tie, impossible in normal play).
//    Else TURNO.
//  FIM: shot_ready=0, shot_valid ignored, all outputs frozen; exit only by reset.
//  shot_valid outside TURNO is ignored (not queued). memoriaP1/P2 change only in CHECK.
//  Latency: shot accept -> enable pulse = 2 cycles. ready -> shot_ready = 1 cycle.
// STRUCTURE
//  Shared package/header: state encodings (LOAD, TURNO, CHECK, REQ, WAIT, FIM), P1/P2 constants, BOARD_BITS=64.
//  One sub-module: mapa_jogador (ship map + shot map + hit map for one side).
//    Exposes test/set ports for idx; two instances, top holds FSM and score latch.
// TESTING
//  Reset, load P1 ship bit0, P2 ship bit9; P1 shoots (1,1) -> shot_hit, memoriaP1[9]=1, turno=0, enable 2 cycles later.
//  P1 shoots (0,0) on empty cell -> shot_hit=0, memoriaP1 unchanged, turno toggles to 1 after CHECK.
//  Same shooter repeats (1,1) -> shot_err pulse, no enable, turno and maps unchanged.
//  Hold ready=0 for 10 cycles in WAIT -> shot_ready=0, shot_valid ignored; ready=1 with pontuacao_P1=3 -> placar_P1=3.
//  Return pontuacao_P2=WIN_SCORE -> fim_jogo=1, vencedor=1, shot_ready stays 0.
//  Assert reset_n=0 during WAIT -> next cycle maps=0, enable=0, state LOAD, turno=FIRST_PLAYER.

Source files
------------

// File: rtl/registro_tiros_pkg.sv
// Shared types and constants for the shot register: FSM states, player ids, board geometry.
package registro_tiros_pkg;

  localparam int BOARD_BITS = 64;
  localparam int IDX_W      = 6;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [2:0] {
    LOAD,
    TURNO,
    CHECK,
    REQ,
    WAIT,
    FIM
  } state_t;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic idx_t cell_idx(input logic [2:0] y, input logic [2:0] x);
    return {y, x};
  endfunction

endpackage

// File: rtl/mapa_jogador.sv
// One player's board: its ship map, the cells the opponent fired at, and the resulting hits.
module mapa_jogador
  import registro_tiros_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_en_i,
  input  logic [BOARD_BITS-1:0] load_map_i,
  input  idx_t                  idx_i,
  input  logic                  set_i,
  output logic                  ship_o,
  output logic                  shot_o,
  output logic [BOARD_BITS-1:0] hit_map_o
);

  logic [BOARD_BITS-1:0] ship_q;
  logic [BOARD_BITS-1:0] shot_q;
  logic [BOARD_BITS-1:0] hit_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ship_q <= '0;
      shot_q <= '0;
      hit_q  <= '0;
    end else begin
      if (load_en_i) ship_q <= load_map_i;
      if (set_i) begin
        shot_q[idx_i] <= 1'b1;
        if (ship_q[idx_i]) hit_q[idx_i] <= 1'b1;
      end
    end
  end

  assign ship_o    = ship_q[idx_i];
  assign shot_o    = shot_q[idx_i];
  assign hit_map_o = hit_q;

endmodule

// File: rtl/registro_tiros.sv
// Turn-based shot register: validates shots against both boards, hands the hit maps to the
// score counter through an enable/ready handshake and latches the returned scores.
module registro_tiros
  import registro_tiros_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE    = 4'd10,
  parameter logic       FIRST_PLAYER = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load_valid,
  input  logic                  load_player,
  input  logic [BOARD_BITS-1:0] load_map,
  input  logic                  shot_valid,
  output logic                  shot_ready,
  input  logic [2:0]            shot_x,
  input  logic [2:0]            shot_y,
  output logic                  shot_err,
  output logic                  shot_hit,
  output logic                  turno,
  output logic [BOARD_BITS-1:0] memoriaP1,
  output logic [BOARD_BITS-1:0] memoriaP2,
  output logic                  enable,
  input  logic                  ready,
  input  logic [3:0]            pontuacao_P1,
  input  logic [3:0]            pontuacao_P2,
  output logic [3:0]            placar_P1,
  output logic [3:0]            placar_P2,
  output logic                  fim_jogo,
  output logic                  vencedor
);

  state_t     state_q;
  logic       turno_q;
  idx_t       idx_q;
  logic [1:0] loaded_q, loaded_d;
  logic       shot_ready_q, shot_err_q, shot_hit_q, enable_q;
  logic [3:0] placar_p1_q, placar_p2_q;
  logic       fim_q, vencedor_q;
  logic       opp;

  logic [1:0]            load_en, set_en, ship_at, shot_at;
  logic [BOARD_BITS-1:0] hit_map [2];

  always_comb begin
    loaded_d = loaded_q;
    if (load_valid && (state_q == LOAD)) loaded_d[load_player] = 1'b1;
    opp = ~turno_q;
  end

  // Board gi is the target of the other player; only the target board is touched in CHECK.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mapa
    assign load_en[gi] = load_valid && (state_q == LOAD) && (load_player == (gi != 0));
    assign set_en[gi]  = (state_q == CHECK) && (opp == (gi != 0)) && !shot_at[gi];

    mapa_jogador u_mapa (
      .clk       (clk),
      .reset_n   (reset_n),
      .load_en_i (load_en[gi]),
      .load_map_i(load_map),
      .idx_i     (idx_q),
      .set_i     (set_en[gi]),
      .ship_o    (ship_at[gi]),
      .shot_o    (shot_at[gi]),
      .hit_map_o (hit_map[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= LOAD;
      turno_q      <= FIRST_PLAYER;
      idx_q        <= '0;
      loaded_q     <= '0;
      shot_ready_q <= 1'b0;
      shot_err_q   <= 1'b0;
      shot_hit_q   <= 1'b0;
      enable_q     <= 1'b0;
      placar_p1_q  <= '0;
      placar_p2_q  <= '0;
      fim_q        <= 1'b0;
      vencedor_q   <= 1'b0;
    end else begin
      shot_err_q <= 1'b0;
      shot_hit_q <= 1'b0;
      enable_q   <= 1'b0;
      case (state_q)
        LOAD: begin
          loaded_q <= loaded_d;
          if (loaded_d == 2'b11) begin
            state_q      <= TURNO;
            shot_ready_q <= 1'b1;
          end
        end
        TURNO: begin
          if (shot_valid && shot_ready_q) begin
            idx_q        <= cell_idx(shot_y, shot_x);
            state_q      <= CHECK;
            shot_ready_q <= 1'b0;
          end
        end
        CHECK: begin
          if (shot_at[opp]) begin
            shot_err_q   <= 1'b1;
            state_q      <= TURNO;
            shot_ready_q <= 1'b1;
          end else begin
            if (ship_at[opp]) shot_hit_q <= 1'b1;
            else              turno_q    <= ~turno_q;
            enable_q <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: state_q <= WAIT;
        WAIT: begin
          if (ready) begin
            placar_p1_q <= pontuacao_P1;
            placar_p2_q <= pontuacao_P2;
            if (pontuacao_P1 >= WIN_SCORE) begin
              fim_q      <= 1'b1;
              vencedor_q <= P1;
              state_q    <= FIM;
            end else if (pontuacao_P2 >= WIN_SCORE) begin
              fim_q      <= 1'b1;
              vencedor_q <= P2;
              state_q    <= FIM;
            end else begin
              state_q      <= TURNO;
              shot_ready_q <= 1'b1;
            end
          end
        end
        FIM:     state_q <= FIM;
        default: state_q <= LOAD;
      endcase
    end
  end

  assign shot_ready = shot_ready_q;
  assign shot_err   = shot_err_q;
  assign shot_hit   = shot_hit_q;
  assign turno      = turno_q;
  assign enable     = enable_q;
  assign memoriaP1  = hit_map[1];
  assign memoriaP2  = hit_map[0];
  assign placar_P1  = placar_p1_q;
  assign placar_P2  = placar_p2_q;
  assign fim_jogo   = fim_q;
  assign vencedor   = vencedor_q;

endmodule
